// File: rtl/bs_word_fifo.sv
// Bitstream word FIFO: packs 32-bit upstream bitstream words into 128-bit entries
// (earliest bit at the MSB) and buffers them for a show-ahead bit parser.
module bs_word_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     bs_valid,
  input  logic [31:0]              bs_data,
  input  logic                     bs_last,
  output logic                     bs_ready,
  input  logic                     codec_data_rd_en,
  output logic [127:0]             codec_data,
  output logic                     codec_data_vld,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underflow_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  logic [127:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [127:0]  pack_q, pack_d;
  logic [1:0]    pack_cnt_q, pack_cnt_d;
  logic          underflow_q, underflow_d;

  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [127:0]  pack_merged;

  // Handshake and push/pop qualification; flush suppresses every transfer.
  always_comb begin
    empty    = (level_q == '0);
    bs_ready = (level_q != LevelFull);
    accept   = bs_valid & bs_ready & ~flush;
    push     = accept & (bs_last | (pack_cnt_q == 2'd3));
    pop      = codec_data_rd_en & ~empty & ~flush;
  end

  // Pack register with the current word dropped into its slot; unwritten slots stay zero.
  always_comb begin
    pack_merged = pack_q;
    case (pack_cnt_q)
      2'd0:    pack_merged[127:96] = bs_data;
      2'd1:    pack_merged[95:64]  = bs_data;
      2'd2:    pack_merged[63:32]  = bs_data;
      default: pack_merged[31:0]   = bs_data;
    endcase
  end

  // Next-state for pointers, level, pack state and the sticky underflow flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pack_d      = pack_q;
    pack_cnt_d  = pack_cnt_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      pack_d      = '0;
      pack_cnt_d  = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (push) begin
        pack_d     = '0;
        pack_cnt_d = '0;
      end else if (accept) begin
        pack_d     = pack_merged;
        pack_cnt_d = pack_cnt_q + 2'd1;
      end
      // A push into an empty FIFO in the same cycle does not make the read legal.
      if (codec_data_rd_en & empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control state, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pack_q      <= '0;
      pack_cnt_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pack_q      <= pack_d;
      pack_cnt_q  <= pack_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage; contents are don't-care until covered by the level count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pack_merged;
    end
  end

  // Show-ahead head entry, forced to zero when empty.
  always_comb begin
    codec_data     = empty ? '0 : mem_q[rd_ptr_q];
    codec_data_vld = ~empty;
    fifo_level     = level_q;
    underflow_err  = underflow_q;
  end

endmodule
